// File: rtl/clk_disp_pkg.sv
// Shared display constants and helpers for the board clock/display blocks.
// Seven-segment codes are {g,f,e,d,c,b,a}, active-high.
package clk_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index n holds the segment code for decimal digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Binary 0..59 to two BCD digits; a compare chain keeps it divider-free.
  function automatic bcd2_t bin_to_bcd2(input logic [5:0] v);
    bcd2_t r;
    r.tens = 4'd0;
    if      (v >= 6'd50) r.tens = 4'd5;
    else if (v >= 6'd40) r.tens = 4'd4;
    else if (v >= 6'd30) r.tens = 4'd3;
    else if (v >= 6'd20) r.tens = 4'd2;
    else if (v >= 6'd10) r.tens = 4'd1;
    r.ones = 4'(v - 6'(r.tens) * 6'd10);
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to seven-segment code; codes above 9 and blank both show nothing.
module seg7_decode
  import clk_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/hms_clock_mux.sv
// HH:MM:SS real-time clock kept in 24 h form, with button setting and a
// scanned seven-segment display (12 h or 24 h presentation).
module hms_clock_mux
  import clk_disp_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 262144
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  inc_min,
  input  logic                  inc_hr,
  input  logic                  mode_12h,
  output logic [6:0]            disp,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  dp,
  output logic                  pm,
  output logic                  tick_1hz,
  output logic [5:0]            sec_o,
  output logic [5:0]            min_o,
  output logic [4:0]            hr_o
);

  localparam int TW  = (CLK_HZ > 1)     ? $clog2(CLK_HZ)     : 1;
  localparam int SW  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // A 4-digit display drops the seconds pair from the bottom of the list.
  localparam int OFS = 6 - NUM_DIGITS;

  logic [TW-1:0] tcnt, tcnt_n;
  logic [5:0]    sec, sec_n;
  logic [5:0]    mins, min_n;
  logic [4:0]    hr, hr_n;
  logic          carry;

  logic [SW-1:0] scnt;
  logic [IW-1:0] idx;
  logic          scan_wrap;

  // ---------------- timekeeping ----------------
  always_comb begin
    tcnt_n = tcnt;
    sec_n  = sec;
    min_n  = mins;
    hr_n   = hr;
    carry  = run && (tcnt == TW'(CLK_HZ - 1));

    if (run) tcnt_n = carry ? '0 : tcnt + 1'b1;

    if (carry) begin
      if (sec == SEC_MAX) begin
        sec_n = '0;
        if (mins == MIN_MAX) begin
          min_n = '0;
          hr_n  = (hr == HR_MAX) ? 5'd0 : hr + 5'd1;
        end else begin
          min_n = mins + 6'd1;
        end
      end else begin
        sec_n = sec + 6'd1;
      end
    end

    // Setting buttons win over the natural carry chain, which is dropped.
    if (inc_min) begin
      tcnt_n = '0;
      sec_n  = '0;
      min_n  = (mins == MIN_MAX) ? 6'd0 : mins + 6'd1;
      hr_n   = hr;
    end
    if (inc_hr) hr_n = (hr == HR_MAX) ? 5'd0 : hr + 5'd1;
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      tcnt     <= '0;
      sec      <= '0;
      mins     <= '0;
      hr       <= '0;
      tick_1hz <= 1'b0;
    end else begin
      tcnt     <= tcnt_n;
      sec      <= sec_n;
      mins     <= min_n;
      hr       <= hr_n;
      tick_1hz <= carry;
    end
  end

  assign sec_o = sec;
  assign min_o = mins;
  assign hr_o  = hr;

  // ---------------- display conversion ----------------
  logic [4:0]          hr_disp;
  bcd2_t               sec_b, min_b, hr_b;
  logic [5:0][3:0]     all_bcd;
  logic [5:0]          all_blank;
  logic [NUM_DIGITS-1:0][6:0] dig_seg;

  always_comb begin
    hr_disp = hr;
    if (mode_12h) begin
      if (hr == 5'd0)       hr_disp = 5'd12;
      else if (hr > 5'd12)  hr_disp = hr - 5'd12;
    end
  end

  assign sec_b = bin_to_bcd2(sec);
  assign min_b = bin_to_bcd2(mins);
  assign hr_b  = bin_to_bcd2({1'b0, hr_disp});

  assign all_bcd   = {hr_b.tens, hr_b.ones, min_b.tens, min_b.ones,
                      sec_b.tens, sec_b.ones};
  assign all_blank = {mode_12h && (hr_b.tens == 4'd0), 5'b0};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seg7_decode u_seg (
      .bcd  (all_bcd[g+OFS]),
      .blank(all_blank[g+OFS]),
      .seg  (dig_seg[g])
    );
  end

  // ---------------- scan ----------------
  assign scan_wrap = (scnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clock) begin
    if (!rst) begin
      scnt  <= '0;
      idx   <= '0;
      disp  <= SEG_BLANK;
      anode <= '0;
      dp    <= 1'b0;
      pm    <= 1'b0;
    end else begin
      scnt <= scan_wrap ? '0 : scnt + 1'b1;
      if (scan_wrap) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      disp  <= dig_seg[idx];
      anode <= NUM_DIGITS'(1) << idx;
      dp    <= ~sec[0];
      pm    <= (hr >= 5'd12);
    end
  end

endmodule
